// File: rtl/regfile_nrd.sv
// Multi-port register file: one synchronous write port, NUM_RD combinational muxed read ports,
// per-register valid bits and an optional hardwired-zero r0. Define RF_BYPASS_EN for write-to-read forwarding.
module regfile_nrd #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD-1:0]        ren,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rvalid,
    output logic [NUM_REGS-1:0]      valid_vec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] valid;
    logic                zero_hit;
    logic                wr_ok;
    logic [ADDR_W-1:0]   ra;

    // r0 stays zero and its valid bit stays set simply because writes to it are blocked
    assign zero_hit = (ZERO_REG != 0) && (waddr == '0);
    assign wr_ok    = wen && !rst && !zero_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            valid <= {{(NUM_REGS-1){1'b0}}, (ZERO_REG != 0)};
        end else if (wr_ok) begin
            regs[waddr]  <= wdata;
            valid[waddr] <= 1'b1;
        end
    end

    always_comb begin
        rdata  = '0;
        rvalid = '0;
        ra     = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (ren[i]) begin
                ra = raddr[i*ADDR_W +: ADDR_W];
                rdata[i*DATA_W +: DATA_W] = regs[ra];
                rvalid[i]                 = valid[ra];
`ifdef RF_BYPASS_EN
                // Forward the in-flight write so the read sees write-before-read ordering
                if (wr_ok && (ra == waddr)) begin
                    rdata[i*DATA_W +: DATA_W] = wdata;
                    rvalid[i]                 = 1'b1;
                end
`endif
            end
        end
    end

    assign valid_vec = valid;

endmodule

// File: tb/tb_regfile_nrd.sv
// Self-checking bench for regfile_nrd: a default instance (16x16, 2 ports, zero r0) and a
// 32-bit, 8-register, 3-port instance with ordinary r0, both checked against an array model.
module tb_regfile_nrd;

    logic        clk;
    logic        rst;

    logic        wen0;
    logic [3:0]  waddr0;
    logic [15:0] wdata0;
    logic [1:0]  ren0;
    logic [7:0]  raddr0;
    logic [31:0] rdata0;
    logic [1:0]  rvalid0;
    logic [15:0] valid_vec0;

    logic        wen1;
    logic [2:0]  waddr1;
    logic [31:0] wdata1;
    logic [2:0]  ren1;
    logic [8:0]  raddr1;
    logic [95:0] rdata1;
    logic [2:0]  rvalid1;
    logic [7:0]  valid_vec1;

    logic [15:0] m0_regs [16];
    bit          m0_valid [16];
    logic [31:0] m1_regs [8];
    bit          m1_valid [8];

    int tests = 0;
    int fails = 0;

    regfile_nrd dut0 (
        .clk(clk), .rst(rst), .wen(wen0), .waddr(waddr0), .wdata(wdata0),
        .ren(ren0), .raddr(raddr0), .rdata(rdata0), .rvalid(rvalid0), .valid_vec(valid_vec0)
    );

    regfile_nrd #(.DATA_W(32), .NUM_REGS(8), .NUM_RD(3), .ZERO_REG(0)) dut1 (
        .clk(clk), .rst(rst), .wen(wen1), .waddr(waddr1), .wdata(wdata1),
        .ren(ren1), .raddr(raddr1), .rdata(rdata1), .rvalid(rvalid1), .valid_vec(valid_vec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus0(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                                  input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1);
        wen0 = w; waddr0 = wa; wdata0 = wd; ren0 = re; raddr0 = {ra1, ra0};
    endtask

    task automatic applyStimulus1(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                                  input logic [2:0] re, input logic [2:0] ra0, input logic [2:0] ra1,
                                  input logic [2:0] ra2);
        wen1 = w; waddr1 = wa; wdata1 = wd; ren1 = re; raddr1 = {ra2, ra1, ra0};
    endtask

    // Expected outputs come from the model state plus the read rules of each instance
    task automatic checkOutput(input string tag);
        logic [3:0]  a0;
        logic [2:0]  a1;
        logic [15:0] e0;
        logic [31:0] e1;
        logic        ev;
        logic [1:0]  ev0;
        logic [2:0]  ev1;
        logic [15:0] vv0;
        logic [7:0]  vv1;
        ev0 = '0;
        ev1 = '0;
        for (int p = 0; p < 2; p++) begin
            a0 = raddr0[p*4 +: 4];
            e0 = '0; ev = 1'b0;
            if (ren0[p]) begin
                if (a0 == 4'd0) begin e0 = '0; ev = 1'b1; end
                else begin e0 = m0_regs[a0]; ev = m0_valid[a0]; end
`ifdef RF_BYPASS_EN
                if (wen0 && !rst && a0 != 4'd0 && a0 == waddr0) begin e0 = wdata0; ev = 1'b1; end
`endif
            end
            ev0[p] = ev;
            compare($sformatf("%s.u0.rdata%0d", tag, p), 32'(rdata0[p*16 +: 16]), 32'(e0));
        end
        compare($sformatf("%s.u0.rvalid", tag), 32'(rvalid0), 32'(ev0));
        for (int r = 0; r < 16; r++) vv0[r] = m0_valid[r];
        compare($sformatf("%s.u0.valid_vec", tag), 32'(valid_vec0), 32'(vv0));

        for (int p = 0; p < 3; p++) begin
            a1 = raddr1[p*3 +: 3];
            e1 = '0; ev = 1'b0;
            if (ren1[p]) begin
                e1 = m1_regs[a1]; ev = m1_valid[a1];
`ifdef RF_BYPASS_EN
                if (wen1 && !rst && a1 == waddr1) begin e1 = wdata1; ev = 1'b1; end
`endif
            end
            ev1[p] = ev;
            compare($sformatf("%s.u1.rdata%0d", tag, p), rdata1[p*32 +: 32], e1);
        end
        compare($sformatf("%s.u1.rvalid", tag), 32'(rvalid1), 32'(ev1));
        for (int r = 0; r < 8; r++) vv1[r] = m1_valid[r];
        compare($sformatf("%s.u1.valid_vec", tag), 32'(valid_vec1), 32'(vv1));
    endtask

    // Advance one clock and apply the register-file rules to the model
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 16; r++) begin m0_regs[r] = '0; m0_valid[r] = (r == 0); end
            for (int r = 0; r < 8; r++)  begin m1_regs[r] = '0; m1_valid[r] = 1'b0; end
        end else begin
            if (wen0 && waddr0 != 4'd0) begin m0_regs[waddr0] = wdata0; m0_valid[waddr0] = 1'b1; end
            if (wen1) begin m1_regs[waddr1] = wdata1; m1_valid[waddr1] = 1'b1; end
        end
        #1;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [2:0]  b;
        rst = 1'b1;
        applyStimulus0(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
        applyStimulus1(1'b0, 3'd0, 32'h0, 3'b000, 3'd0, 3'd0, 3'd0);
        tick();
        tick();
        rst = 1'b0;

        // Empty reads after reset
        applyStimulus0(1'b0, 4'd0, 16'h0, 2'b11, 4'd3, 4'd5);
        applyStimulus1(1'b0, 3'd0, 32'h0, 3'b111, 3'd0, 3'd1, 3'd2);
        #2 checkOutput("reset");
        compare("reset.u0.vv_const", 32'(valid_vec0), 32'h0001);
        compare("reset.u0.rvalid_const", 32'(rvalid0), 32'h0);

        // Write then read on both ports
        applyStimulus0(1'b1, 4'd3, 16'hBEEF, 2'b00, 4'd0, 4'd0);
        #2 checkOutput("wr_r3");
        tick();
        applyStimulus0(1'b0, 4'd0, 16'h0, 2'b11, 4'd3, 4'd3);
        #2 checkOutput("rd_r3");
        compare("rd_r3.u0.data_const", rdata0, 32'hBEEF_BEEF);
        compare("rd_r3.u0.vv_const", 32'(valid_vec0), 32'h0009);

        // Register 0 protection vs ordinary r0
        applyStimulus0(1'b1, 4'd0, 16'h1234, 2'b00, 4'd0, 4'd0);
        applyStimulus1(1'b1, 3'd0, 32'h1234, 3'b000, 3'd0, 3'd0, 3'd0);
        #2 checkOutput("wr_r0");
        tick();
        applyStimulus0(1'b0, 4'd0, 16'h0, 2'b11, 4'd0, 4'd0);
        applyStimulus1(1'b0, 3'd0, 32'h0, 3'b001, 3'd0, 3'd0, 3'd0);
        #2 checkOutput("rd_r0");
        compare("rd_r0.u0.data_const", rdata0, 32'h0);
        compare("rd_r0.u0.rvalid_const", 32'(rvalid0), 32'h3);
        compare("rd_r0.u1.data_const", rdata1[31:0], 32'h1234);

        // Same-cycle read and write of r7
        applyStimulus0(1'b1, 4'd7, 16'h00AA, 2'b00, 4'd0, 4'd0);
        applyStimulus1(1'b0, 3'd0, 32'h0, 3'b000, 3'd0, 3'd0, 3'd0);
        tick();
        applyStimulus0(1'b1, 4'd7, 16'h5555, 2'b01, 4'd7, 4'd0);
        #2 checkOutput("rw_r7");
`ifdef RF_BYPASS_EN
        compare("rw_r7.u0.data_const", 32'(rdata0[15:0]), 32'h5555);
`else
        compare("rw_r7.u0.data_const", 32'(rdata0[15:0]), 32'h00AA);
`endif
        tick();
        applyStimulus0(1'b0, 4'd0, 16'h0, 2'b01, 4'd7, 4'd0);
        #2 checkOutput("rw_r7_next");
        compare("rw_r7_next.u0.data_const", 32'(rdata0[15:0]), 32'h5555);

        // Reset takes priority over a simultaneous write
        rst = 1'b1;
        applyStimulus0(1'b1, 4'd2, 16'hFFFF, 2'b00, 4'd0, 4'd0);
        tick();
        rst = 1'b0;
        applyStimulus0(1'b0, 4'd0, 16'h0, 2'b01, 4'd2, 4'd0);
        #2 checkOutput("rst_vs_wr");
        compare("rst_vs_wr.u0.data_const", 32'(rdata0[15:0]), 32'h0);
        compare("rst_vs_wr.u0.rvalid_const", 32'(rvalid0), 32'h0);

        // Disabled port gives zeros even on a valid register
        applyStimulus0(1'b1, 4'd4, 16'h4444, 2'b00, 4'd0, 4'd0);
        tick();
        applyStimulus0(1'b0, 4'd0, 16'h0, 2'b01, 4'd4, 4'd4);
        #2 checkOutput("port_dis");
        compare("port_dis.u0.p1_data_const", 32'(rdata0[31:16]), 32'h0);
        compare("port_dis.u0.p1_valid_const", 32'(rvalid0[1]), 32'h0);

        // Wide instance: fill all 8 registers, then read them back three at a time
        applyStimulus0(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus1(1'b1, 3'(i), 32'hA5A5_0000 + 32'(i), 3'b000, 3'd0, 3'd0, 3'd0);
            #2 checkOutput($sformatf("fill%0d", i));
            tick();
        end
        for (int i = 0; i < 8; i += 3) begin
            b = 3'(i);
            applyStimulus1(1'b0, 3'd0, 32'h0, 3'b111, b, b + 3'd1, b + 3'd2);
            #2 checkOutput($sformatf("sweep%0d", i));
            compare($sformatf("sweep%0d.u1.data_const", i), rdata1[31:0], 32'hA5A5_0000 + 32'(i));
            compare($sformatf("sweep%0d.u1.vv_const", i), 32'(valid_vec1), 32'hFF);
            tick();
        end

        // Random traffic against the model, with occasional resets
        for (int n = 0; n < 400; n++) begin
            rnd = $urandom;
            rst = ($urandom_range(0, 39) == 0);
            applyStimulus0(rnd[0], 4'($urandom), 16'($urandom), rnd[2:1],
                           rnd[3] ? waddr0 : 4'($urandom), 4'($urandom));
            applyStimulus1(rnd[4], 3'($urandom), $urandom, rnd[7:5],
                           rnd[8] ? waddr1 : 3'($urandom), 3'($urandom), 3'($urandom));
            if (rnd[3]) raddr0[3:0] = waddr0;
            if (rnd[8]) raddr1[2:0] = waddr1;
            #2 checkOutput($sformatf("rand%0d", n));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_nrd.md
Name: regfile_nrd

Overview:
- Parametrised multi-port register file for the single-cycle processor, built as the successor of the per-bit storage cell.
- One synchronous write port and NUM_RD combinational read ports.
- Read data is driven onto plain muxed outputs, not tristate bitlines.
- Adds a per-register valid (written-since-reset) bit and an optional hardwired-zero register 0. Sits between decode and ALU.

Parameters:
DATA_W, 16, width of each register in bits
NUM_REGS, 16, number of registers; power of two, at least 2
ADDR_W, $clog2(NUM_REGS), address width; derived, do not override
NUM_RD, 2, number of read ports; 1 to 4
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
wen  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
ren  input  NUM_RD  per-port read enable; bit i is port i
raddr  input  NUM_RD*ADDR_W  read addresses, flattened; port i is bits [i*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  read data, flattened; port i is bits [i*DATA_W +: DATA_W]
rvalid  output  NUM_RD  bit i = 1 when port i is enabled and the addressed register has been written since reset
valid_vec  output  NUM_REGS  raw valid bit per register

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising clk edge):
  - all registers clear to 0;
  - all valid bits clear to 0, except bit 0, which is 1 when ZERO_REG=1.
  - rst takes priority over a simultaneous write; that write is dropped.
- Write:
  - when wen=1 and rst=0 at a rising edge, reg[waddr] <= wdata and valid[waddr] <= 1.
  - Write latency: 1 cycle. Data is visible on the read ports from the next cycle on.
- Register 0, ZERO_REG=1:
  - writes to address 0 are ignored, including the valid bit;
  - reads of address 0 return 0 with rvalid=1 (when enabled).
- Read port i, combinational from ren/raddr and register state:
  - ren[i]=1: rdata_i = reg[raddr_i], rvalid[i] = valid[raddr_i];
  - ren[i]=0: rdata_i = 0, rvalid[i] = 0. Outputs are never X or Z.
- Multiple read ports may address the same register in the same cycle; each returns identical data.
- Read and write to the same address in the same cycle, without bypass: the read returns the old value and old valid bit.
- valid_vec is the registered valid bit vector; it is unaffected by ren.
- Out-of-range addresses cannot occur, since NUM_REGS is a power of two.
- Output values after reset: rdata=0, rvalid=0, except rvalid[i]=1 for ports enabled on address 0 when ZERO_REG=1. valid_vec = 0 or 1 (bit 0 only, with ZERO_REG=1).

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - when wen=1, rst=0, ren[i]=1 and raddr_i == waddr (excluding address 0 with ZERO_REG=1), then rdata_i = wdata and rvalid[i] = 1 in the same cycle.
  - This gives write-before-read semantics with zero-cycle forwarding.
  - rst=1 suppresses the bypass.
- Not defined: read-before-write semantics as described in Behaviour; no forwarding logic is synthesised.

Test Plan:
1. Reset and empty reads: assert rst for 2 cycles, then ren=2'b11, raddr=(3,5) -> rdata=(0,0), rvalid=2'b00, valid_vec=16'h0001 (ZERO_REG=1).
2. Write then read: write 16'hBEEF to r3, next cycle read r3 on both ports -> both rdata=16'hBEEF, rvalid=2'b11, valid_vec=16'h0009.
3. Register 0 protection: write 16'h1234 to r0, next cycle read r0 -> rdata=0, rvalid=1, valid_vec bit 0 unchanged; repeat with ZERO_REG=0 -> rdata=16'h1234.
4. Same-cycle read/write of r7 (old value 16'h00AA, new value 16'h5555):
   - without RF_BYPASS_EN -> rdata=16'h00AA that cycle, 16'h5555 the next;
   - with RF_BYPASS_EN -> 16'h5555 immediately.
5. Reset versus write: rst=1 together with a write of 16'hFFFF to r2 -> next cycle r2 reads 0 with rvalid=0.
6. Disabled port and parameter sweep: ren=2'b01 -> port 1 gives rdata=0, rvalid=0. Rerun tests 1-5 with DATA_W=32, NUM_REGS=8, NUM_RD=3, reading all 8 registers back after writing each one with value 0xA5A50000+index.
